fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request interface. It increments the PC by 4 per fetched instruction and applies branch/jump redirects with flush. It presents one fetched instruction at a time to decode with a valid/stall handshake. It replaces the free-running PC/PC-adder pair with a controlled, stallable fetch stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment per sequential fetch
TIMEOUT, 16, max cycles in REQ without IMEM_ACK before TIMEOUT_ERR pulses (range 2..255)

Ports:
CLK  in  1  clock; all state changes on posedge
RESET  in  1  synchronous, active-high; sampled on posedge CLK
BR_TAKEN  in  1  branch redirect request
BR_TARGET  in  32  branch target address
JMP  in  1  jump redirect request
JMP_TARGET  in  32  jump target address
STALL  in  1  decode cannot accept INSTR this cycle
IMEM_REQ  out  1  fetch request to instruction memory
IMEM_ADDR  out  32  fetch address, equals PC_OUT
IMEM_ACK  in  1  IMEM_RDATA valid for IMEM_ADDR this cycle
IMEM_RDATA  in  32  fetched instruction word
INSTR  out  32  registered instruction to decode
INSTR_PC  out  32  address INSTR was fetched from
INSTR_VALID  out  1  INSTR/INSTR_PC valid
PC_OUT  out  32  current program counter
ALIGN_ERR  out  1  one-cycle pulse: redirect target[1:0] != 0
TIMEOUT_ERR  out  1  one-cycle pulse: fetch timeout

Behaviour:
- Reset: PC=RESET_PC, state=IDLE. IMEM_REQ, INSTR_VALID, ALIGN_ERR and TIMEOUT_ERR are 0. INSTR=0, INSTR_PC=0, timeout counter=0. RESET overrides every other input.
- States: IDLE, REQ, HOLD. All outputs are registered except IMEM_REQ (=state==REQ) and IMEM_ADDR (=PC).
- IDLE: unconditional transition to REQ on the next cycle. The first IMEM_REQ is asserted 1 cycle after RESET deasserts.
- REQ: IMEM_REQ=1, IMEM_ADDR=PC held stable.
  - On IMEM_ACK: INSTR<=IMEM_RDATA, INSTR_PC<=PC, INSTR_VALID<=1, PC<=PC+PC_STEP (mod 2^32; 32'hFFFF_FFFC wraps to 0), go to HOLD.
- HOLD: IMEM_REQ=0, INSTR_VALID=1, INSTR held.
  - STALL=1: remain in HOLD.
  - STALL=0: instruction is consumed this cycle; INSTR_VALID<=0, go to REQ.
  - Throughput: 1 instruction per 2 cycles with a zero-wait memory.
- Redirect: BR_TAKEN or JMP, evaluated in any non-reset state.
  - BR_TAKEN has priority over JMP when both are high.
  - Effects: PC<={target[31:2],2'b00}, INSTR_VALID<=0 (flush), next state=REQ, timeout counter cleared.
  - Redirect in the same cycle as IMEM_ACK: RDATA is discarded and PC takes the target, not PC+4.
  - Redirect in HOLD: the held instruction is dropped regardless of STALL.
- ALIGN_ERR pulses in the cycle after an accepted redirect whose selected target[1:0] != 0. The cleared-bit target is still used.
- Timeout: counter increments each REQ cycle without ACK.
  - When it reaches TIMEOUT-1 without ACK: TIMEOUT_ERR pulses next cycle, counter clears, request stays asserted at the same address.
  - Counter clears on ACK, redirect, or leaving REQ.
- One outstanding request at most. No request is issued while INSTR_VALID=1.

Decomposition:
- Shared package fetch_pkg:
  - state enum (IDLE, REQ, HOLD)
  - PC_W=32 and INSTR_W=32
  - RESET_PC and PC_STEP defaults
- One combinational sub-module, next_pc_sel. Inputs: PC, ACK, BR_TAKEN, BR_TARGET, JMP, JMP_TARGET. Outputs: next PC, redirect flag, misalign flag. It implements the priority and alignment rules; the FSM, counter and output registers stay in fetch_ctrl.

Test Plan:
- Reset then zero-wait memory (ACK=1 whenever REQ), STALL=0 -> IMEM_ADDR sequence 0,4,8,C on REQ cycles; INSTR_VALID high every 2nd cycle; INSTR_PC matches each address.
- STALL=1 for 3 cycles during HOLD at PC 0x8 -> INSTR and INSTR_PC=0x8 held, no IMEM_REQ. After STALL drops, the next REQ address is 0xC.
- BR_TAKEN=1 (BR_TARGET=0x100) and JMP=1 (JMP_TARGET=0x200) in the same cycle as ACK for 0x10 -> RDATA discarded, INSTR_VALID=0, next IMEM_ADDR=0x100.
- JMP with JMP_TARGET=0x203 -> ALIGN_ERR one-cycle pulse; next IMEM_ADDR=0x200.
- ACK held low with TIMEOUT=16 -> TIMEOUT_ERR pulses after 16 REQ cycles, repeats every 16; address unchanged. ACK then completes the fetch normally.
- PC preset to 0xFFFFFFFC via jump, ACK -> next IMEM_ADDR=0x0. RESET asserted mid-HOLD -> all outputs return to reset values next cycle and PC=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned     PC_STEP_DEF  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold
    } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: redirect priority (branch over jump), target alignment
// and sequential increment on an accepted fetch.
module next_pc_sel
    import fetch_pkg::*;
#(
    parameter int unsigned PC_STEP = PC_STEP_DEF
) (
    input  logic [PC_W-1:0] pc,
    input  logic            ack,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp,
    input  logic [PC_W-1:0] jmp_target,
    output logic [PC_W-1:0] next_pc,
    output logic            redirect,
    output logic            misalign
);

    logic [PC_W-1:0] target;

    // Redirect wins over sequential advance; low target bits are forced to zero.
    always_comb begin
        redirect = br_taken | jmp;
        target   = br_taken ? br_target : jmp_target;
        misalign = redirect && (target[1:0] != 2'b00);
        if (redirect) begin
            next_pc = {target[PC_W-1:2], 2'b00};
        end else if (ack) begin
            next_pc = pc + PC_W'(PC_STEP);
        end else begin
            next_pc = pc;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one IMEM request at a time
// and hands each fetched word to decode through a valid/stall handshake.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned     PC_STEP  = PC_STEP_DEF,
    parameter int unsigned     TIMEOUT  = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               BR_TAKEN,
    input  logic [PC_W-1:0]    BR_TARGET,
    input  logic               JMP,
    input  logic [PC_W-1:0]    JMP_TARGET,
    input  logic               STALL,
    output logic               IMEM_REQ,
    output logic [PC_W-1:0]    IMEM_ADDR,
    input  logic               IMEM_ACK,
    input  logic [INSTR_W-1:0] IMEM_RDATA,
    output logic [INSTR_W-1:0] INSTR,
    output logic [PC_W-1:0]    INSTR_PC,
    output logic               INSTR_VALID,
    output logic [PC_W-1:0]    PC_OUT,
    output logic               ALIGN_ERR,
    output logic               TIMEOUT_ERR
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    fetch_state_e        state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [PC_W-1:0]     instr_pc_q, instr_pc_d;
    logic                valid_q, valid_d;
    logic                align_q, align_d;
    logic                tout_q, tout_d;
    logic [7:0]          cnt_q, cnt_d;

    logic                fetch_ack;
    logic [PC_W-1:0]     sel_pc;
    logic                redirect;
    logic                misalign;

    // An ACK only means something while a request is outstanding.
    assign fetch_ack = (state_q == StReq) && IMEM_ACK;

    next_pc_sel #(
        .PC_STEP (PC_STEP)
    ) u_next_pc_sel (
        .pc         (pc_q),
        .ack        (fetch_ack),
        .br_taken   (BR_TAKEN),
        .br_target  (BR_TARGET),
        .jmp        (JMP),
        .jmp_target (JMP_TARGET),
        .next_pc    (sel_pc),
        .redirect   (redirect),
        .misalign   (misalign)
    );

    // Next-state logic for the FSM, timeout counter and decode-side registers.
    always_comb begin
        state_d    = state_q;
        pc_d       = sel_pc;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        align_d    = 1'b0;
        tout_d     = 1'b0;
        cnt_d      = cnt_q;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
                cnt_d   = '0;
            end
            StReq: begin
                if (IMEM_ACK) begin
                    instr_d    = IMEM_RDATA;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    state_d    = StHold;
                    cnt_d      = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // Keep requesting the same address; just flag the stall.
                    tout_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StHold: begin
                cnt_d = '0;
                if (!STALL) begin
                    valid_d = 1'b0;
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // A redirect flushes anything fetched or held and abandons the request.
        if (redirect) begin
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
            valid_d    = 1'b0;
            state_d    = StReq;
            cnt_d      = '0;
            tout_d     = 1'b0;
            align_d    = misalign;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            align_q    <= 1'b0;
            tout_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            align_q    <= align_d;
            tout_q     <= tout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign IMEM_REQ    = (state_q == StReq);
    assign IMEM_ADDR   = pc_q;
    assign PC_OUT      = pc_q;
    assign INSTR       = instr_q;
    assign INSTR_PC    = instr_pc_q;
    assign INSTR_VALID = valid_q;
    assign ALIGN_ERR   = align_q;
    assign TIMEOUT_ERR = tout_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl: a stimulus/expectation table plus a
// hand-written timeout sequence.
module tb_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        BR_TAKEN;
    logic [31:0] BR_TARGET;
    logic        JMP;
    logic [31:0] JMP_TARGET;
    logic        STALL;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK;
    logic [31:0] IMEM_RDATA;
    logic [31:0] INSTR;
    logic [31:0] INSTR_PC;
    logic        INSTR_VALID;
    logic [31:0] PC_OUT;
    logic        ALIGN_ERR;
    logic        TIMEOUT_ERR;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4),
        .TIMEOUT  (16)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .BR_TAKEN    (BR_TAKEN),
        .BR_TARGET   (BR_TARGET),
        .JMP         (JMP),
        .JMP_TARGET  (JMP_TARGET),
        .STALL       (STALL),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_ACK    (IMEM_ACK),
        .IMEM_RDATA  (IMEM_RDATA),
        .INSTR       (INSTR),
        .INSTR_PC    (INSTR_PC),
        .INSTR_VALID (INSTR_VALID),
        .PC_OUT      (PC_OUT),
        .ALIGN_ERR   (ALIGN_ERR),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    typedef struct packed {
        logic        rst;
        logic        br;
        logic [31:0] brt;
        logic        jmp;
        logic [31:0] jt;
        logic        stall;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_valid;
        logic        e_align;
        logic        e_tout;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rst, input logic br, input logic [31:0] brt,
                                input logic jmp, input logic [31:0] jt, input logic stall,
                                input logic ack, input logic [31:0] rdata, input logic e_req,
                                input logic [31:0] e_pc, input logic [31:0] e_instr,
                                input logic [31:0] e_ipc, input logic e_valid,
                                input logic e_align, input logic e_tout);
        vec_t v;
        v.rst = rst; v.br = br; v.brt = brt; v.jmp = jmp; v.jt = jt;
        v.stall = stall; v.ack = ack; v.rdata = rdata;
        v.e_req = e_req; v.e_pc = e_pc; v.e_instr = e_instr; v.e_ipc = e_ipc;
        v.e_valid = e_valid; v.e_align = e_align; v.e_tout = e_tout;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        RESET      = v.rst;
        BR_TAKEN   = v.br;
        BR_TARGET  = v.brt;
        JMP        = v.jmp;
        JMP_TARGET = v.jt;
        STALL      = v.stall;
        IMEM_ACK   = v.ack;
        IMEM_RDATA = v.rdata;
    endtask

    task automatic compare(input vec_t v, input int idx);
        check("imem_req",    idx, 32'(IMEM_REQ),    32'(v.e_req));
        check("imem_addr",   idx, IMEM_ADDR,        v.e_pc);
        check("pc_out",      idx, PC_OUT,           v.e_pc);
        check("instr",       idx, INSTR,            v.e_instr);
        check("instr_pc",    idx, INSTR_PC,         v.e_ipc);
        check("instr_valid", idx, 32'(INSTR_VALID), 32'(v.e_valid));
        check("align_err",   idx, 32'(ALIGN_ERR),   32'(v.e_align));
        check("timeout_err", idx, 32'(TIMEOUT_ERR), 32'(v.e_tout));
    endtask

    localparam logic [31:0] I0 = 32'h1000_0013, I1 = 32'h2000_0093, I2 = 32'h3000_0113;
    localparam logic [31:0] I3 = 32'h4000_0193, I4 = 32'h5000_0213, I5 = 32'h6000_0293;
    localparam logic [31:0] I6 = 32'h7000_0313, I7 = 32'h8000_0393, I8 = 32'h9000_0413;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    vec_t tv;

    initial begin
        //              rst br brt           jmp jt            stl ack rdata | req pc            instr ipc          v  al to
        vecs[0]  = mk(1, 0, 0,            0, 0,            0, 0, 0,    0, 32'h0,        0,  32'h0,        0, 0, 0);
        vecs[1]  = mk(1, 1, 32'h55,       0, 0,            0, 1, JUNK, 0, 32'h0,        0,  32'h0,        0, 0, 0);
        vecs[2]  = mk(0, 0, 0,            0, 0,            0, 0, 0,    1, 32'h0,        0,  32'h0,        0, 0, 0);
        vecs[3]  = mk(0, 0, 0,            0, 0,            0, 1, I0,   0, 32'h4,        I0, 32'h0,        1, 0, 0);
        vecs[4]  = mk(0, 0, 0,            0, 0,            0, 1, JUNK, 1, 32'h4,        I0, 32'h0,        0, 0, 0);
        vecs[5]  = mk(0, 0, 0,            0, 0,            0, 1, I1,   0, 32'h8,        I1, 32'h4,        1, 0, 0);
        vecs[6]  = mk(0, 0, 0,            0, 0,            0, 1, JUNK, 1, 32'h8,        I1, 32'h4,        0, 0, 0);
        vecs[7]  = mk(0, 0, 0,            0, 0,            0, 1, I2,   0, 32'hC,        I2, 32'h8,        1, 0, 0);
        // Stall three cycles in HOLD; a stray ACK must not matter.
        vecs[8]  = mk(0, 0, 0,            0, 0,            1, 1, JUNK, 0, 32'hC,        I2, 32'h8,        1, 0, 0);
        vecs[9]  = mk(0, 0, 0,            0, 0,            1, 1, JUNK, 0, 32'hC,        I2, 32'h8,        1, 0, 0);
        vecs[10] = mk(0, 0, 0,            0, 0,            1, 1, JUNK, 0, 32'hC,        I2, 32'h8,        1, 0, 0);
        vecs[11] = mk(0, 0, 0,            0, 0,            0, 0, 0,    1, 32'hC,        I2, 32'h8,        0, 0, 0);
        vecs[12] = mk(0, 0, 0,            0, 0,            0, 1, I3,   0, 32'h10,       I3, 32'hC,        1, 0, 0);
        vecs[13] = mk(0, 0, 0,            0, 0,            0, 0, 0,    1, 32'h10,       I3, 32'hC,        0, 0, 0);
        // Branch and jump together with ACK: branch wins, data dropped.
        vecs[14] = mk(0, 1, 32'h100,      1, 32'h200,      0, 1, JUNK, 1, 32'h100,      I3, 32'hC,        0, 0, 0);
        vecs[15] = mk(0, 0, 0,            0, 0,            0, 1, I4,   0, 32'h104,      I4, 32'h100,      1, 0, 0);
        // Misaligned jump while stalled in HOLD.
        vecs[16] = mk(0, 0, 0,            1, 32'h203,      1, 0, 0,    1, 32'h200,      I4, 32'h100,      0, 1, 0);
        vecs[17] = mk(0, 0, 0,            0, 0,            0, 0, 0,    1, 32'h200,      I4, 32'h100,      0, 0, 0);
        vecs[18] = mk(0, 0, 0,            0, 0,            0, 1, I5,   0, 32'h204,      I5, 32'h200,      1, 0, 0);
        vecs[19] = mk(0, 1, 32'h301,      0, 0,            0, 0, 0,    1, 32'h300,      I5, 32'h200,      0, 1, 0);
        // Aligned branch beats misaligned jump: no alignment error.
        vecs[20] = mk(0, 1, 32'h400,      1, 32'h502,      0, 0, 0,    1, 32'h400,      I5, 32'h200,      0, 0, 0);
        vecs[21] = mk(0, 0, 0,            1, 32'hFFFF_FFFC, 0, 0, 0,   1, 32'hFFFF_FFFC, I5, 32'h200,     0, 0, 0);
        vecs[22] = mk(0, 0, 0,            0, 0,            0, 1, I6,   0, 32'h0,        I6, 32'hFFFF_FFFC, 1, 0, 0);
        vecs[23] = mk(0, 0, 0,            0, 0,            0, 0, 0,    1, 32'h0,        I6, 32'hFFFF_FFFC, 0, 0, 0);
        vecs[24] = mk(0, 0, 0,            0, 0,            0, 1, I7,   0, 32'h4,        I7, 32'h0,        1, 0, 0);
        vecs[25] = mk(0, 0, 0,            0, 0,            1, 0, 0,    0, 32'h4,        I7, 32'h0,        1, 0, 0);
        // Reset mid-HOLD overrides stall and ACK.
        vecs[26] = mk(1, 0, 0,            0, 0,            1, 1, JUNK, 0, 32'h0,        0,  32'h0,        0, 0, 0);
        vecs[27] = mk(0, 0, 0,            0, 0,            0, 0, 0,    1, 32'h0,        0,  32'h0,        0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            @(posedge CLK);
            #1;
            compare(vecs[i], i);
        end

        // ACK withheld: TIMEOUT_ERR every 16th REQ cycle, address never moves.
        tv = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 32'h0, 0, 0, 0);
        drive(tv);
        for (int n = 1; n <= 40; n++) begin
            @(posedge CLK);
            #1;
            tv.e_tout = (n % 16 == 0);
            compare(tv, 100 + n);
        end

        // Late ACK completes the fetch normally.
        tv = mk(0, 0, 0, 0, 0, 0, 1, I8, 0, 32'h4, I8, 32'h0, 1, 0, 0);
        drive(tv);
        @(posedge CLK);
        #1;
        compare(tv, 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
